// File: rtl/note_playback_scheduler_pkg.sv
// Shared definitions for the note playback path: default widths, the
// stored event word layout and the scheduler state encoding.
package note_playback_scheduler_pkg;

    localparam int TS_BITS   = 29;
    localparam int NOTE_BITS = 5;
    localparam int unsigned MAX_TIME = 300000000;

    // Event word layout: {on_flag, note, timestamp}
    localparam int TS_LSB     = 0;
    localparam int NOTE_LSB   = TS_BITS;
    localparam int ON_BIT     = TS_BITS + NOTE_BITS;
    localparam int EVENT_BITS = ON_BIT + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        WAIT_TIME,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/playback_tick_gen.sv
// Playback timebase: prescaler producing one tick every TICK_DIV clocks and a
// saturating play_time counter. Also used by the metronome.
module playback_tick_gen #(
    parameter int          TS_BITS  = 29,
    parameter int          TICK_DIV = 1000000,
    parameter int unsigned MAX_TIME = 300000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               clear,
    input  logic               pause,
    output logic               tick,
    output logic [TS_BITS-1:0] play_time
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [TS_BITS-1:0] PT_MAX     = TS_BITS'(MAX_TIME);

    logic [PRESC_W-1:0] prescaler;

    assign tick = run && !pause && !clear && (prescaler == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            play_time <= '0;
        end else if (clear) begin
            prescaler <= '0;
            play_time <= '0;
        end else if (run && !pause) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick && play_time != PT_MAX)
                play_time <= play_time + 1'b1;
        end
    end

endmodule

// File: rtl/note_playback_scheduler.sv
// Walks the recorded event list and emits each note event once the playback
// timebase reaches its stored timestamp.
module note_playback_scheduler #(
    parameter int          TS_BITS   = note_playback_scheduler_pkg::TS_BITS,
    parameter int          NOTE_BITS = note_playback_scheduler_pkg::NOTE_BITS,
    parameter int          ADDR_BITS = 10,
    parameter int          TICK_DIV  = 1000000,
    parameter int unsigned MAX_TIME  = note_playback_scheduler_pkg::MAX_TIME
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           pause,
    input  logic [ADDR_BITS:0]             event_count,
    output logic                           rd_en,
    output logic [ADDR_BITS-1:0]           rd_addr,
    input  logic [TS_BITS+NOTE_BITS:0]     rd_data,
    output logic                           note_valid,
    output logic [NOTE_BITS-1:0]           note_code,
    output logic                           note_on,
    output logic [TS_BITS-1:0]             play_time,
    output logic                           playing,
    output logic                           done
);

    import note_playback_scheduler_pkg::*;

    localparam logic [TS_BITS-1:0] PT_MAX = TS_BITS'(MAX_TIME);

    state_t state, state_next;

    logic [ADDR_BITS:0]           count;
    logic [TS_BITS+NOTE_BITS:0]   ev;
    logic [TS_BITS+NOTE_BITS:0]   src;
    logic                         start_ok, load_ev, load_note, addr_clr, addr_inc;
    logic                         last, tb_clear;

    function automatic logic reached(input logic [TS_BITS-1:0] pt,
                                     input logic [TS_BITS-1:0] ts);
        return (pt >= ts) || (pt == PT_MAX);
    endfunction

    assign rd_en   = (state == FETCH);
    assign playing = (state == FETCH) || (state == WAIT_DATA) ||
                     (state == WAIT_TIME) || (state == EMIT);
    assign done    = (state == DONE);
    assign last    = ({1'b0, rd_addr} == count - 1'b1);
    // WAIT_DATA tests the word straight off the read port so an already-due
    // event skips WAIT_TIME and keeps the 3-cycle-per-event rate.
    assign src     = (state == WAIT_DATA) ? rd_data : ev;
    assign tb_clear = start_ok || (state_next == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        load_ev    = 1'b0;
        load_note  = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    start_ok   = 1'b1;
                    state_next = (event_count == '0) ? DONE : FETCH;
                end
            end
            FETCH:
                state_next = stop ? IDLE : WAIT_DATA;
            WAIT_DATA, WAIT_TIME: begin
                if (stop) begin
                    state_next = IDLE;
                end else begin
                    load_ev = (state == WAIT_DATA);
                    if (reached(play_time, src[TS_LSB +: TS_BITS])) begin
                        load_note  = 1'b1;
                        state_next = EMIT;
                    end else begin
                        state_next = WAIT_TIME;
                    end
                end
            end
            EMIT: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end else begin
                    addr_inc   = 1'b1;
                    state_next = FETCH;
                end
            end
            default:
                state_next = IDLE;
        endcase
        if (start_ok || state_next == IDLE)
            addr_clr = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            rd_addr    <= '0;
            ev         <= '0;
            note_valid <= 1'b0;
            note_code  <= '0;
            note_on    <= 1'b0;
        end else begin
            note_valid <= load_note;
            if (start_ok)
                count <= event_count;
            if (addr_clr)
                rd_addr <= '0;
            else if (addr_inc)
                rd_addr <= rd_addr + 1'b1;
            if (load_ev)
                ev <= rd_data;
            if (load_note) begin
                note_code <= src[NOTE_LSB +: NOTE_BITS];
                note_on   <= src[ON_BIT];
            end
        end
    end

    playback_tick_gen #(
        .TS_BITS  (TS_BITS),
        .TICK_DIV (TICK_DIV),
        .MAX_TIME (MAX_TIME)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (playing),
        .clear     (tb_clear),
        .pause     (pause),
        .tick      (),
        .play_time (play_time)
    );

endmodule

// File: tb/tb_note_playback_scheduler.sv
// Directed bench for note_playback_scheduler with a strobe scoreboard.
module tb_note_playback_scheduler;

    typedef struct packed {
        logic [4:0]  note;
        logic        on;
        logic [28:0] pt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, stop, pause;
    logic [10:0] event_count;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [34:0] rd_data;
    logic        note_valid;
    logic [4:0]  note_code;
    logic        note_on;
    logic [28:0] play_time;
    logic        playing, done;

    logic [34:0] mem [16];
    exp_t        sb[$];
    int          emit_cycs[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          rd_cnt = 0;

    note_playback_scheduler #(
        .TICK_DIV (4),
        .MAX_TIME (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .event_count (event_count),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .note_valid  (note_valid),
        .note_code   (note_code),
        .note_on     (note_on),
        .play_time   (play_time),
        .playing     (playing),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) rd_cnt++;
            if (note_valid) begin
                exp_t e;
                strobes++;
                emit_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_note", note_code, e.note);
                    check("sb_on", note_on, e.on);
                    check("sb_time", play_time, e.pt);
                end
            end
        end
    end

    function automatic logic [34:0] mk(input logic on, input logic [4:0] n, input logic [28:0] ts);
        return {on, n, ts};
    endfunction

    function automatic exp_t ex(input logic [4:0] n, input logic on, input logic [28:0] pt);
        exp_t e;
        e.note = n; e.on = on; e.pt = pt;
        return e;
    endfunction

    task automatic pulse_start(input logic [10:0] cnt);
        event_count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic wait_pt(input logic [28:0] v, input int budget);
        int n = 0;
        while (play_time != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("time_reached", play_time, v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, note_valid, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_code"}, note_code, 0);
        check({tag, "_on"}, note_on, 0);
        check({tag, "_time"}, play_time, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int s, d1, d2, r0, s0;
        logic [28:0] p0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; event_count = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: press at t=0, release at t=2
        mem[0] = mk(1'b1, 5'd3, 29'd0);
        mem[1] = mk(1'b0, 5'd3, 29'd2);
        strobes = 0;
        sb.push_back(ex(5'd3, 1'b1, 29'd0));
        sb.push_back(ex(5'd3, 1'b0, 29'd2));
        pulse_start(11'd2);
        wait_done(200);
        check("t1_strobes", strobes, 2);
        check("t1_sb_empty", sb.size(), 0);
        check("t1_playing", playing, 0);
        check("t1_time_held", play_time, 2);
        pulse_stop();
        check("t1_stop_done", done, 0);

        // 2: three equal timestamps emitted back-to-back while time is held at 5
        mem[0] = mk(1'b1, 5'd1, 29'd5);
        mem[1] = mk(1'b1, 5'd2, 29'd5);
        mem[2] = mk(1'b1, 5'd4, 29'd5);
        strobes = 0;
        emit_cycs.delete();
        for (int i = 0; i < 3; i++) sb.push_back(ex(mem[i][33:29], 1'b1, 29'd5));
        pulse_start(11'd3);
        wait_pt(29'd5, 200);
        pause = 1'b1;
        wait_done(100);
        pause = 1'b0;
        check("t2_strobes", strobes, 3);
        if (emit_cycs.size() == 3) begin
            check("t2_gap01", emit_cycs[1] - emit_cycs[0], 3);
            check("t2_gap12", emit_cycs[2] - emit_cycs[1], 3);
        end
        pulse_stop();

        // 3: empty list
        r0 = rd_cnt;
        strobes = 0;
        pulse_start(11'd0);
        check("t3_done", done, 1);
        check("t3_no_read", rd_cnt - r0, 0);
        check("t3_no_strobe", strobes, 0);
        pulse_stop();
        check("t3_stop_done", done, 0);

        // 4: same event without and with a 20-cycle pause
        mem[0] = mk(1'b1, 5'd9, 29'd3);
        sb.push_back(ex(5'd9, 1'b1, 29'd3));
        emit_cycs.delete();
        s = cyc;
        pulse_start(11'd1);
        wait_done(200);
        d1 = (emit_cycs.size() == 1) ? emit_cycs[0] - s : -1;
        pulse_stop();
        sb.push_back(ex(5'd9, 1'b1, 29'd3));
        emit_cycs.delete();
        s = cyc;
        pulse_start(11'd1);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        p0 = play_time;
        repeat (20) @(negedge clk);
        check("t4_frozen", play_time, p0);
        pause = 1'b0;
        wait_done(200);
        d2 = (emit_cycs.size() == 1) ? emit_cycs[0] - s : -1000;
        check("t4_delay", d2 - d1, 20);
        pulse_stop();

        // 5: stop while waiting, then replay from address 0
        mem[0] = mk(1'b1, 5'd6, 29'd10);
        strobes = 0;
        pulse_start(11'd1);
        wait_pt(29'd4, 100);
        pulse_stop();
        check("t5_playing", playing, 0);
        check("t5_time", play_time, 0);
        check("t5_done", done, 0);
        check("t5_no_strobe", strobes, 0);
        mem[0] = mk(1'b0, 5'd11, 29'd1);
        sb.push_back(ex(5'd11, 1'b0, 29'd1));
        pulse_start(11'd1);
        wait_done(200);
        check("t5_replay_strobes", strobes, 1);
        pulse_stop();

        // 6: timestamp beyond saturation, then reset mid-playback
        mem[0] = mk(1'b1, 5'd20, 29'd13);
        sb.push_back(ex(5'd20, 1'b1, 29'd8));
        pulse_start(11'd1);
        wait_done(300);
        repeat (5) @(negedge clk);
        check("t6_sat_time", play_time, 8);
        check("t6_sat_done", done, 1);
        pulse_stop();
        pulse_start(11'd1);
        repeat (6) @(negedge clk);
        check("t6_playing", playing, 1);
        s0 = strobes;
        reset = 1'b1;
        #1;
        check_all_zero("t6_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_no_strobe", strobes, s0);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
